// File: rtl/sort_array_memory.sv
// rtl/sort_array_memory.sv - word-addressed array memory with AR/R and AW/W/B valid/ready channels
// plus a side load port and a combinational inspect port for preloading and checking the array.
module sort_array_memory #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ar_valid,
  input  logic [ADDR_WDTH-1:0] ar_addr,
  output logic                 ar_ready,
  output logic                 r_valid,
  output logic [DATA_WDTH-1:0] r_data,
  input  logic                 r_ready,
  input  logic                 aw_valid,
  input  logic [ADDR_WDTH-1:0] aw_addr,
  output logic                 aw_ready,
  input  logic                 w_valid,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 w_ready,
  output logic                 b_valid,
  output logic [RESP_WDTH-1:0] b_resp,
  input  logic                 b_ready,
  input  logic                 ld_en,
  input  logic [ADDR_WDTH-1:0] ld_addr,
  input  logic [DATA_WDTH-1:0] ld_data,
  input  logic [ADDR_WDTH-1:0] dbg_addr,
  output logic [DATA_WDTH-1:0] dbg_data
);

  localparam logic [0:0] R_IDLE    = 1'b0;
  localparam logic [0:0] R_RESP    = 1'b1;
  localparam logic [0:0] W_COLLECT = 1'b0;
  localparam logic [0:0] W_RESP    = 1'b1;
  localparam logic [ADDR_WDTH:0] DEPTH_L = (ADDR_WDTH + 1)'(DEPTH);

  logic [DATA_WDTH-1:0] mem_q [DEPTH];
  logic [DATA_WDTH-1:0] mem_d [DEPTH];

  logic                 r_state_q, r_state_d;
  logic [DATA_WDTH-1:0] r_data_q, r_data_d;
  logic                 w_state_q, w_state_d;
  logic                 aw_got_q, aw_got_d;
  logic                 w_got_q, w_got_d;
  logic [ADDR_WDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WDTH-1:0] w_data_q, w_data_d;
  logic [RESP_WDTH-1:0] b_resp_q, b_resp_d;
  logic                 ready_en_q, ready_en_d;

  logic                 commit;
  logic [ADDR_WDTH-1:0] wr_addr;
  logic [DATA_WDTH-1:0] wr_data;
  logic                 have_aw, have_w;

  // Readies stay low for the first edge after reset so they first show 1 the cycle after rst falls.
  assign ar_ready = ready_en_q & ~rst & (r_state_q == R_IDLE);
  assign r_valid  = ~rst & (r_state_q == R_RESP);
  assign r_data   = rst ? '0 : r_data_q;
  assign aw_ready = ready_en_q & ~rst & (w_state_q == W_COLLECT) & ~aw_got_q;
  assign w_ready  = ready_en_q & ~rst & (w_state_q == W_COLLECT) & ~w_got_q;
  assign b_valid  = ~rst & (w_state_q == W_RESP);
  assign b_resp   = rst ? '0 : b_resp_q;
  assign dbg_data = ({1'b0, dbg_addr} < DEPTH_L) ? mem_q[dbg_addr] : '0;

  always_comb begin
    r_state_d  = r_state_q;
    r_data_d   = r_data_q;
    w_state_d  = w_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    b_resp_d   = b_resp_q;
    ready_en_d = 1'b1;
    commit     = 1'b0;
    have_aw    = aw_got_q | (aw_valid & aw_ready);
    have_w     = w_got_q | (w_valid & w_ready);
    wr_addr    = aw_got_q ? aw_addr_q : aw_addr;
    wr_data    = w_got_q ? w_data_q : w_data;

    if (r_state_q == R_IDLE) begin
      if (ar_valid && ar_ready) begin
        r_data_d  = ({1'b0, ar_addr} < DEPTH_L) ? mem_q[ar_addr] : '0;
        r_state_d = R_RESP;
      end
    end else if (r_ready) begin
      r_state_d = R_IDLE;
    end

    if (w_state_q == W_COLLECT) begin
      if (have_aw && have_w) begin
        commit    = 1'b1;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        b_resp_d  = ({1'b0, wr_addr} < DEPTH_L) ? '0 : RESP_WDTH'(1'b1);
        w_state_d = W_RESP;
      end else begin
        if (aw_valid && aw_ready) begin
          aw_got_d  = 1'b1;
          aw_addr_d = aw_addr;
        end
        if (w_valid && w_ready) begin
          w_got_d  = 1'b1;
          w_data_d = w_data;
        end
      end
    end else if (b_ready) begin
      w_state_d = W_COLLECT;
    end

    // Side load first so a same-index AXI commit on the same edge overrides it.
    mem_d = mem_q;
    if (ld_en && ({1'b0, ld_addr} < DEPTH_L)) begin
      mem_d[ld_addr] = ld_data;
    end
    if (commit && ({1'b0, wr_addr} < DEPTH_L)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      r_data_q   <= '0;
      w_state_q  <= W_COLLECT;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      b_resp_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_data_q   <= r_data_d;
      w_state_q  <= w_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      b_resp_q   <= b_resp_d;
      ready_en_q <= ready_en_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_sort_array_memory.sv
// tb/tb_sort_array_memory.sv - directed self-checking bench for sort_array_memory (DEPTH=10).
module tb_sort_array_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]  ar_addr;
  logic [31:0] r_data;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [3:0]  aw_addr;
  logic [31:0] w_data;
  logic [0:0]  b_resp;
  logic        ld_en;
  logic [3:0]  ld_addr, dbg_addr;
  logic [31:0] ld_data, dbg_data;

  logic [31:0] exp_mem [10];
  int errors = 0;
  int checks = 0;

  sort_array_memory #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .DEPTH(10)) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < 10; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk($sformatf("%s_mem%0d", tag, i), dbg_data, exp_mem[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b0;
    aw_valid = 1'b0; aw_addr = '0; w_valid = 1'b0; w_data = '0; b_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    tick();

    // Preload during reset: {7,3,9,1} then 0x100+i
    for (int i = 0; i < 10; i++) begin
      exp_mem[i] = (i == 0) ? 32'd7 : (i == 1) ? 32'd3 : (i == 2) ? 32'd9 : (i == 3) ? 32'd1 : 32'h100 + 32'(i);
      ld_en = 1'b1; ld_addr = 4'(i); ld_data = exp_mem[i];
      tick();
    end
    ld_en = 1'b0;
    chk("rst_ar_ready", {31'd0, ar_ready}, 32'd0);
    chk("rst_aw_ready", {31'd0, aw_ready}, 32'd0);
    chk("rst_w_ready", {31'd0, w_ready}, 32'd0);
    chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_fall_ar_ready", {31'd0, ar_ready}, 32'd0);
    tick();
    chk("post_rst_ar_ready", {31'd0, ar_ready}, 32'd1);
    chk("post_rst_aw_ready", {31'd0, aw_ready}, 32'd1);
    chk_mem("preload");

    // Single read of index 2
    ar_valid = 1'b1; ar_addr = 4'd2; r_ready = 1'b1;
    tick();
    ar_valid = 1'b0;
    chk("rd2_r_valid", {31'd0, r_valid}, 32'd1);
    chk("rd2_r_data", r_data, 32'd9);
    chk("rd2_ar_ready", {31'd0, ar_ready}, 32'd0);
    tick();
    chk("rd2_done_r_valid", {31'd0, r_valid}, 32'd0);

    // Back-to-back reads, one per 2 cycles
    ar_valid = 1'b1; ar_addr = 4'd0;
    tick();
    chk("b2b_a_valid", {31'd0, r_valid}, 32'd1);
    chk("b2b_a_data", r_data, 32'd7);
    ar_addr = 4'd3;
    tick();
    chk("b2b_gap_valid", {31'd0, r_valid}, 32'd0);
    chk("b2b_gap_ar_ready", {31'd0, ar_ready}, 32'd1);
    tick();
    ar_valid = 1'b0;
    chk("b2b_b_valid", {31'd0, r_valid}, 32'd1);
    chk("b2b_b_data", r_data, 32'd1);
    tick();

    // AW and W in the same cycle
    aw_valid = 1'b1; aw_addr = 4'd1; w_valid = 1'b1; w_data = 32'h55; b_ready = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    exp_mem[1] = 32'h55;
    chk("wsame_b_valid", {31'd0, b_valid}, 32'd1);
    chk("wsame_b_resp", {31'd0, b_resp}, 32'd0);
    chk("wsame_aw_ready", {31'd0, aw_ready}, 32'd0);
    dbg_addr = 4'd1;
    #1;
    chk("wsame_dbg", dbg_data, 32'h55);
    tick();
    chk("wsame_done_b_valid", {31'd0, b_valid}, 32'd0);

    // W three cycles before AW
    w_valid = 1'b1; w_data = 32'hAA;
    tick();
    w_valid = 1'b0;
    chk("wfirst_w_ready", {31'd0, w_ready}, 32'd0);
    chk("wfirst_aw_ready", {31'd0, aw_ready}, 32'd1);
    chk("wfirst_b_valid", {31'd0, b_valid}, 32'd0);
    tick();
    tick();
    aw_valid = 1'b1; aw_addr = 4'd5;
    tick();
    aw_valid = 1'b0;
    exp_mem[5] = 32'hAA;
    chk("wfirst_b_valid_after_aw", {31'd0, b_valid}, 32'd1);
    chk("wfirst_b_resp", {31'd0, b_resp}, 32'd0);
    tick();

    // AW first
    aw_valid = 1'b1; aw_addr = 4'd6;
    tick();
    aw_valid = 1'b0;
    chk("awfirst_aw_ready", {31'd0, aw_ready}, 32'd0);
    chk("awfirst_w_ready", {31'd0, w_ready}, 32'd1);
    chk("awfirst_b_valid", {31'd0, b_valid}, 32'd0);
    tick();
    w_valid = 1'b1; w_data = 32'hBB;
    tick();
    w_valid = 1'b0;
    exp_mem[6] = 32'hBB;
    chk("awfirst_b_valid_after_w", {31'd0, b_valid}, 32'd1);
    tick();
    chk_mem("after_ordered_writes");

    // Out-of-range write and read
    aw_valid = 1'b1; aw_addr = 4'd12; w_valid = 1'b1; w_data = 32'hDEAD;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("oor_b_valid", {31'd0, b_valid}, 32'd1);
    chk("oor_b_resp", {31'd0, b_resp}, 32'd1);
    tick();
    chk_mem("after_oor_write");
    ar_valid = 1'b1; ar_addr = 4'd12;
    tick();
    ar_valid = 1'b0;
    chk("oor_r_valid", {31'd0, r_valid}, 32'd1);
    chk("oor_r_data", r_data, 32'd0);
    dbg_addr = 4'd12;
    #1;
    chk("oor_dbg", dbg_data, 32'd0);
    tick();

    // Read accepted on the same edge as a write commit to the same index
    aw_valid = 1'b1; aw_addr = 4'd3; w_valid = 1'b1; w_data = 32'h11;
    ar_valid = 1'b1; ar_addr = 4'd3;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    exp_mem[3] = 32'h11;
    chk("raw_same_r_data", r_data, 32'd1);
    chk("raw_same_b_valid", {31'd0, b_valid}, 32'd1);
    tick();
    ar_valid = 1'b1; ar_addr = 4'd3;
    tick();
    ar_valid = 1'b0;
    chk("raw_later_r_data", r_data, 32'h11);
    tick();

    // Side load colliding with AXI commit on the same index: AXI wins
    aw_valid = 1'b1; aw_addr = 4'd7; w_valid = 1'b1; w_data = 32'h77;
    ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'h99;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; ld_en = 1'b0;
    exp_mem[7] = 32'h77;
    dbg_addr = 4'd7;
    #1;
    chk("ld_vs_axi", dbg_data, 32'h77);
    tick();

    // r_ready held low, then reset during R_RESP
    r_ready = 1'b0;
    ar_valid = 1'b1; ar_addr = 4'd4;
    tick();
    ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall%0d_r_valid", i), {31'd0, r_valid}, 32'd1);
      chk($sformatf("stall%0d_r_data", i), r_data, 32'h104);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_r_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_mid_r_data", r_data, 32'd0);
    tick();
    chk("rst_held_r_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_held_ar_ready", {31'd0, ar_ready}, 32'd0);
    rst = 1'b0;
    r_ready = 1'b1;
    tick();
    chk("rst2_ar_ready", {31'd0, ar_ready}, 32'd1);
    chk("rst2_r_valid", {31'd0, r_valid}, 32'd0);
    chk_mem("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_array_memory.md
Name: sort_array_memory

Overview:
- Word-addressed array memory that serves the insertion-sort controller/datapath pair over a valid/ready memory interface.
- Channels: AR/R for reads; AW/W/B for writes, with B carrying a response.
- Holds the array being sorted in place.
- A side load/inspect port lets the system or bench preload the array before start and check it after done.

Parameters:
- ADDR_WDTH, 4, address width; addresses are element indices, not byte addresses.
- DATA_WDTH, 32, element width.
- RESP_WDTH, 1, width of b_resp.
- DEPTH, 16, number of implemented words; must satisfy DEPTH <= 2**ADDR_WDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ar_valid  input  1  read address valid.
- ar_addr  input  ADDR_WDTH  read index.
- ar_ready  output  1  read address accepted.
- r_valid  output  1  read data valid.
- r_data  output  DATA_WDTH  read data.
- r_ready  input  1  read data consumed.
- aw_valid  input  1  write address valid.
- aw_addr  input  ADDR_WDTH  write index.
- aw_ready  output  1  write address accepted.
- w_valid  input  1  write data valid.
- w_data  input  DATA_WDTH  write data.
- w_ready  output  1  write data accepted.
- b_valid  output  1  write response valid.
- b_resp  output  RESP_WDTH  0 = OKAY, 1 = ERROR (zero-extended).
- b_ready  input  1  write response consumed.
- ld_en  input  1  side-port write enable.
- ld_addr  input  ADDR_WDTH  side-port write index.
- ld_data  input  DATA_WDTH  side-port write data.
- dbg_addr  input  ADDR_WDTH  inspect index.
- dbg_data  output  DATA_WDTH  combinational mem[dbg_addr]; 0 if dbg_addr >= DEPTH.

Behaviour:
- Reset:
  - rst sampled on clk only; while high, all outputs except dbg_data are 0.
  - Both FSMs go idle; captured AW/W flags clear; pending R/B responses are discarded.
  - Memory contents are NOT reset.
  - ar_ready/aw_ready/w_ready first read 1 in the cycle after rst falls.
- Read FSM (R_IDLE, R_RESP):
  - R_IDLE: ar_ready=1, r_valid=0.
  - Handshake on ar_valid & ar_ready: latch r_data = mem[ar_addr] (pre-edge contents), or 0 if ar_addr >= DEPTH; go to R_RESP.
  - R_RESP: ar_ready=0, r_valid=1; r_data stable until r_valid & r_ready, then go to R_IDLE.
  - Latency: r_valid rises the cycle after the AR handshake. Peak rate is one read per 2 cycles when r_ready is held high.
- Write FSM (W_COLLECT, W_RESP), with flags aw_got and w_got:
  - W_COLLECT: aw_ready = !aw_got; w_ready = !w_got.
  - Each handshake captures its address or data and sets its flag. AW and W may arrive in either order or in the same cycle.
  - On the edge where both are held (including same-cycle arrival):
    - if addr < DEPTH: write mem[addr] = data, b_resp=0;
    - else: drop the write, b_resp=1;
    - clear both flags and go to W_RESP.
  - W_RESP: aw_ready=w_ready=0, b_valid=1, b_resp stable until b_valid & b_ready, then go to W_COLLECT.
  - Latency: b_valid rises the cycle after the later of the AW/W handshakes.
- Read/write ordering:
  - Read and write FSMs are independent and may be active simultaneously.
  - A read accepted on the same edge as a write commit to the same index returns the OLD value.
  - A read accepted on any later edge returns the new value.
- Side port:
  - ld_en writes mem[ld_addr] = ld_data on the edge; ignored if ld_addr >= DEPTH.
  - On the same edge and same index as an AXI commit, the AXI write wins.
  - ld_en is honoured during rst.
- Valid/ready rules:
  - Outputs never depend combinationally on any *_valid or *_ready input.
  - Once asserted, r_valid/b_valid and their payloads hold until the handshake.

Test Plan:
- Preload mem[0..3]={7,3,9,1} via ld_en; AR addr 2 with r_ready=1 -> r_valid one cycle after handshake, r_data=9, ar_ready=0 in that cycle; back-to-back reads sustain one read per 2 cycles.
- AW addr 1 and W data 0x55 in the same cycle, b_ready=1 -> b_valid next cycle, b_resp=0; dbg_addr=1 reads 0x55.
- W data 0xAA three cycles before AW addr 5 -> w_ready=0 after W capture, b_valid cycle after AW, mem[5]=0xAA; repeat with AW first -> same result.
- Write to addr 12 with DEPTH=10 -> b_resp=1, no word changes; read of addr 12 -> r_data=0.
- Write addr 3 = 0x11 commits on the same edge an AR for addr 3 is accepted (old value 1) -> r_data=1; subsequent read -> 0x11.
- Hold r_ready=0 for 4 cycles during R_RESP, then assert rst -> r_valid holds data stable, then 0 during reset; ar_ready=1 the cycle after rst falls; memory unchanged.
